// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 op encodings, FSM state enum and operand-signedness helpers.
package muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } state_t;

    function automatic logic a_is_signed(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic b_is_signed(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration on unsigned magnitudes: shift-add multiply (multiplier in the
// low half) or restoring divide ({remainder, quotient} shifted left).
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH-1:0] acc_out
);

    logic [WIDTH:0]   add_sum;
    logic [2*WIDTH:0] shifted;
    logic [WIDTH:0]   diff;

    // Divide: diff[WIDTH] is the borrow, so clear means the trial subtract fits.
    always_comb begin
        add_sum = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + {1'b0, operand};
        shifted = {acc_in, 1'b0};
        diff    = shifted[2*WIDTH:WIDTH] - {1'b0, operand};
        if (is_div) begin
            if (!diff[WIDTH])
                acc_out = {diff[WIDTH-1:0], shifted[WIDTH-1:1], 1'b1};
            else
                acc_out = shifted[2*WIDTH-1:0];
        end else if (acc_in[0]) begin
            acc_out = {add_sum, acc_in[WIDTH-1:1]};
        end else begin
            acc_out = {1'b0, acc_in[2*WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: WIDTH magnitude iterations followed by
// one sign-fix cycle; divide-by-zero and signed overflow skip the iterations.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t             state, next_state;
    logic [CNT_W-1:0]   count;
    logic [2*WIDTH-1:0] acc, step_out;
    logic [WIDTH-1:0]   operand_b, a_q;
    logic [2:0]         op_q;
    logic               neg_a, neg_b, div_zero_q, ovf_q;

    logic               a_neg_in, b_neg_in, div_zero_in, ovf_in, last_iter;
    logic [WIDTH-1:0]   mag_a_in, mag_b_in;
    logic [2*WIDTH-1:0] prod_signed;
    logic [WIDTH-1:0]   quot_signed, rem_signed, fix_result;

    always_comb begin
        a_neg_in    = a_is_signed(op) & a[WIDTH-1];
        b_neg_in    = b_is_signed(op) & b[WIDTH-1];
        mag_a_in    = a_neg_in ? -a : a;
        mag_b_in    = b_neg_in ? -b : b;
        div_zero_in = op[2] && (b == '0);
        ovf_in      = ((op == OP_DIV) || (op == OP_REM)) &&
                      (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
        last_iter   = (count == CNT_W'(WIDTH - 1));
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (op_q[2]),
        .acc_in  (acc),
        .operand (operand_b),
        .acc_out (step_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (in_valid) next_state = (div_zero_in || ovf_in) ? ST_FIX : ST_CALC;
            ST_CALC: if (last_iter) next_state = ST_FIX;
            ST_FIX:  next_state = ST_DONE;
            ST_DONE: if (out_ready) next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Quotient is negated when signs differ; the remainder follows the dividend.
    always_comb begin
        prod_signed = (neg_a ^ neg_b) ? -acc : acc;
        quot_signed = (neg_a ^ neg_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_signed  = neg_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        fix_result  = '0;
        if (div_zero_q)
            fix_result = op_q[1] ? a_q : '1;
        else if (ovf_q)
            fix_result = op_q[1] ? '0 : a_q;
        else begin
            case (op_q)
                OP_MUL:                        fix_result = prod_signed[WIDTH-1:0];
                OP_MULH, OP_MULHSU, OP_MULHU:  fix_result = prod_signed[2*WIDTH-1:WIDTH];
                OP_DIV, OP_DIVU:               fix_result = quot_signed;
                default:                       fix_result = rem_signed;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= '0;
            acc        <= '0;
            operand_b  <= '0;
            a_q        <= '0;
            op_q       <= '0;
            neg_a      <= 1'b0;
            neg_b      <= 1'b0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
            result     <= '0;
        end else begin
            case (state)
                ST_IDLE: if (in_valid) begin
                    op_q       <= op;
                    a_q        <= a;
                    operand_b  <= mag_b_in;
                    neg_a      <= a_neg_in;
                    neg_b      <= b_neg_in;
                    div_zero_q <= div_zero_in;
                    ovf_q      <= ovf_in;
                    acc        <= {{WIDTH{1'b0}}, mag_a_in};
                    count      <= '0;
                end
                ST_CALC: begin
                    acc   <= step_out;
                    count <= count + 1'b1;
                end
                ST_FIX:  result <= fix_result;
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign out_valid = (state == ST_DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M corner cases plus random
// operations, scored each cycle against a plain-arithmetic reference model.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready, busy;
    logic [31:0] a, b, result;
    logic [2:0]  op;
    logic        stim_done;
    int          cyc;
    int          n_vec, n_err;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          acc_at;
    } exp_t;
    exp_t exp_q[$];

    muldiv_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc++;

    // RV32M semantics straight from 64-bit arithmetic; SV division truncates toward zero.
    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx = longint'($signed(x));
        longint      sy = longint'($signed(y));
        longint      ux = longint'({32'b0, x});
        longint      uy = longint'({32'b0, y});
        logic [63:0] p;
        p = '0;
        if (o[2] && y == 32'd0) return o[1] ? x : 32'hFFFF_FFFF;
        case (o)
            OP_MUL:    p = sx * sy;
            OP_MULH:   p = sx * sy;
            OP_MULHSU: p = sx * uy;
            OP_MULHU:  p = ux * uy;
            OP_DIV:    p = sx / sy;
            OP_DIVU:   p = ux / uy;
            OP_REM:    p = sx % sy;
            default:   p = ux % uy;
        endcase
        if (o == OP_MULH || o == OP_MULHSU || o == OP_MULHU) return p[63:32];
        return p[31:0];
    endfunction

    function automatic int ref_lat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        if (o[2] && y == 32'd0) return 1;
        if ((o == OP_DIV || o == OP_REM) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, got, want);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        op = o; a = x; b = y; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic waitResult(input int hold);
        int n;
        n = 0;
        while (!out_valid && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (hold) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    // Compare process: pins the model, then scores the DUT on every falling edge.
    initial begin
        exp_t cur;
        logic seen, prev_hs;
        n_vec = 0; n_err = 0; seen = 1'b0; prev_hs = 1'b0;
        checkOutput("model MUL 7*-3",       ref_model(OP_MUL,    32'd7,          32'hFFFF_FFFD), 32'hFFFF_FFEB);
        checkOutput("model MULHU",          ref_model(OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF), 32'hFFFF_FFFE);
        checkOutput("model MULH",           ref_model(OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF), 32'h0000_0000);
        checkOutput("model MULHSU",         ref_model(OP_MULHSU, 32'hFFFF_FFFF,  32'd2),         32'hFFFF_FFFF);
        checkOutput("model DIV -7/2",       ref_model(OP_DIV,    32'hFFFF_FFF9,  32'd2),         32'hFFFF_FFFD);
        checkOutput("model REM -7%2",       ref_model(OP_REM,    32'hFFFF_FFF9,  32'd2),         32'hFFFF_FFFF);
        checkOutput("model DIVU",           ref_model(OP_DIVU,   32'hFFFF_FFF9,  32'd2),         32'h7FFF_FFFC);
        checkOutput("model DIVU by zero",   ref_model(OP_DIVU,   32'd5,          32'd0),         32'hFFFF_FFFF);
        checkOutput("model REMU by zero",   ref_model(OP_REMU,   32'd5,          32'd0),         32'd5);
        checkOutput("model DIV overflow",   ref_model(OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF), 32'h8000_0000);
        checkOutput("model REM overflow",   ref_model(OP_REM,    32'h8000_0000,  32'hFFFF_FFFF), 32'd0);
        checkOutput("model latency MUL",    ref_lat(OP_MUL,  32'd7, 32'd3),                      32'd33);
        checkOutput("model latency div0",   ref_lat(OP_DIVU, 32'd5, 32'd0),                      32'd1);
        checkOutput("model latency DIVU ov",ref_lat(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF),      32'd33);
        forever begin
            @(negedge clk);
            if (stim_done) begin
                checkOutput("queue drained", exp_q.size(), 0);
                $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
                $finish;
            end
            if (!rst_n) begin
                checkOutput("reset out_valid", out_valid, 1'b0);
                checkOutput("reset busy",      busy,      1'b0);
                checkOutput("reset in_ready",  in_ready,  1'b1);
                checkOutput("reset result",    result,    32'd0);
                exp_q.delete();
                seen = 1'b0;
                prev_hs = 1'b0;
            end else begin
                checkOutput("in_ready vs busy", in_ready, !busy);
                if (prev_hs) checkOutput("idle after handshake", in_ready, 1'b1);
                if (out_valid) begin
                    checkOutput("busy while valid", busy, 1'b1);
                    if (exp_q.size() == 0) begin
                        checkOutput("spurious out_valid", out_valid, 1'b0);
                    end else begin
                        cur = exp_q[0];
                        if (!seen) begin
                            checkOutput("latency", cyc - cur.acc_at, cur.lat);
                            seen = 1'b1;
                        end
                        checkOutput("result", result, cur.res);
                        if (out_ready) begin
                            void'(exp_q.pop_front());
                            seen = 1'b0;
                        end
                    end
                end else if (exp_q.size() > 0 && !seen && cyc - exp_q[0].acc_at > exp_q[0].lat) begin
                    checkOutput("out_valid overdue", cyc - exp_q[0].acc_at, exp_q[0].lat);
                    void'(exp_q.pop_front());
                end
                prev_hs = out_valid && out_ready;
                if (in_valid && in_ready) begin
                    cur.res    = ref_model(op, a, b);
                    cur.lat    = ref_lat(op, a, b);
                    cur.acc_at = cyc + 1;
                    exp_q.push_back(cur);
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed corners: {op, a, b}.
    localparam int N_DIR = 12;
    logic [2:0]  dir_op [N_DIR] = '{OP_MUL, OP_MULHU, OP_MULH, OP_MULHSU, OP_DIV, OP_REM,
                                    OP_DIVU, OP_DIVU, OP_REMU, OP_DIV, OP_REM, OP_DIVU};
    logic [31:0] dir_a  [N_DIR] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                    32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd5, 32'd5,
                                    32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] dir_b  [N_DIR] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2,
                                    32'd2, 32'd2, 32'd2, 32'd0, 32'd0,
                                    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

    initial begin
        logic [31:0] x, y;
        logic [2:0]  o;
        int          r;
        stim_done = 1'b0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < N_DIR; i++) begin
            applyStimulus(dir_op[i], dir_a[i], dir_b[i]);
            waitResult(0);
        end

        // Hold the result for 5 cycles while a new request waits, then release.
        applyStimulus(OP_MUL, 32'd7, 32'hFFFF_FFFD);
        for (int n = 0; n < 60 && !out_valid; n++) begin @(posedge clk); #1; end
        op = OP_DIVU; a = 32'd100; b = 32'd7; in_valid = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        waitResult(0);

        // Abandon an operation partway through its iterations.
        applyStimulus(OP_MULHU, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (40) begin @(posedge clk); #1; end
        applyStimulus(OP_REM, 32'hFFFF_FF9C, 32'd7);
        waitResult(1);

        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 9);
            o = 3'($urandom_range(0, 7));
            x = $urandom;
            y = $urandom;
            if (r == 0) y = 32'd0;
            else if (r == 1) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
            else if (r == 2) y = $urandom_range(1, 15);
            else if (r == 3) x = $urandom_range(0, 255);
            applyStimulus(o, x, y);
            waitResult($urandom_range(0, 2));
        end

        repeat (3) @(posedge clk);
        stim_done = 1'b1;
    end

endmodule
